// File: rtl/rr_select_arbiter.sv
// Four-requester round-robin arbiter with registered active-low one-hot select,
// break-before-make between owners and an optional per-ownership hold limit.
module rr_select_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt_n,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t     state_q, state_d;
  logic [1:0] gnt_idx_q, gnt_idx_d;
  logic [3:0] gnt_n_q, gnt_n_d;
  logic       gnt_vld_q, gnt_vld_d;
  logic       timeout_q, timeout_d;
  logic [1:0] last_q, last_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;

  logic [1:0] cand;
  logic [1:0] win;
  logic       win_vld;

  // Circular scan starting just after the last owner, so that owner ranks lowest.
  always_comb begin
    cand    = '0;
    win     = '0;
    win_vld = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!win_vld && req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    gnt_n_d    = gnt_n_q;
    gnt_vld_d  = gnt_vld_q;
    timeout_d  = 1'b0;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (en && win_vld) begin
          state_d    = GRANT;
          gnt_idx_d  = win;
          gnt_n_d    = ~(4'b0001 << win);
          gnt_vld_d  = 1'b1;
          last_d     = win;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        // A release on the same edge as the limit wins, so no timeout pulse then.
        if (!req[gnt_idx_q]) begin
          state_d   = IDLE;
          gnt_n_d   = 4'b1111;
          gnt_vld_d = 1'b0;
        end else if (HOLD_MAX != 0 && hold_cnt_q == HOLD_LAST) begin
          state_d   = IDLE;
          gnt_n_d   = 4'b1111;
          gnt_vld_d = 1'b0;
          timeout_d = 1'b1;
        end else if (hold_cnt_q != 8'hff) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        gnt_n_d   = 4'b1111;
        gnt_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_idx_q  <= 2'b00;
      gnt_n_q    <= 4'b1111;
      gnt_vld_q  <= 1'b0;
      timeout_q  <= 1'b0;
      last_q     <= 2'd3;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_n_q    <= gnt_n_d;
      gnt_vld_q  <= gnt_vld_d;
      timeout_q  <= timeout_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt_n   = gnt_n_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Bench for rr_select_arbiter: a behavioural model queues expected outputs per
// cycle for a HOLD_MAX=8 and a HOLD_MAX=0 instance; scenario tasks add fixed checks.
module tb_rr_select_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt_n, gnt_n0;
  logic [1:0] gnt_idx, gnt_idx0;
  logic       gnt_vld, gnt_vld0, timeout, timeout0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rr_select_arbiter #(.HOLD_MAX(8)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt_n(gnt_n), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .timeout(timeout)
  );

  rr_select_arbiter #(.HOLD_MAX(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt_n(gnt_n0), .gnt_idx(gnt_idx0), .gnt_vld(gnt_vld0), .timeout(timeout0)
  );

  typedef struct packed {
    logic       vld;
    logic [1:0] idx;
    logic [3:0] gn;
    logic       to;
    logic [1:0] last;
    logic [7:0] cnt;
  } mst_t;

  localparam mst_t RST_ST = '{vld: 1'b0, idx: 2'd0, gn: 4'hf, to: 1'b0, last: 2'd3, cnt: 8'd0};

  mst_t m8 = RST_ST;
  mst_t m0 = RST_ST;
  logic [7:0] sb8[$];
  logic [7:0] sb0[$];
  logic [7:0] e8, e0;

  function automatic mst_t mnext(mst_t s, logic [3:0] r, logic e, logic rs, int hm);
    mst_t n = s;
    logic found = 1'b0;
    logic [1:0] w;
    n.to = 1'b0;
    if (rs) return RST_ST;
    if (!s.vld) begin
      if (e) begin
        for (int k = 1; k <= 4; k++) begin
          w = 2'((int'(s.last) + k) % 4);
          if (!found && r[w]) begin
            found = 1'b1;
            n.vld = 1'b1; n.idx = w; n.gn = ~(4'b0001 << w); n.last = w; n.cnt = 8'd0;
          end
        end
      end
    end else if (!r[s.idx]) begin
      n.vld = 1'b0; n.gn = 4'hf;
    end else if (hm != 0 && int'(s.cnt) == hm - 1) begin
      n.vld = 1'b0; n.gn = 4'hf; n.to = 1'b1;
    end else if (s.cnt != 8'hff) begin
      n.cnt = s.cnt + 8'd1;
    end
    return n;
  endfunction

  function automatic logic [7:0] pack(mst_t s);
    return {s.gn, s.idx, s.vld, s.to};
  endfunction

  // Drive one cycle of stimulus, queue the model's expectation, land #1 after the edge.
  task automatic apply(input logic [3:0] r, input logic e, input logic rs);
    req = r; en = e; rst = rs;
    m8 = mnext(m8, r, e, rs, 8);
    m0 = mnext(m0, r, e, rs, 0);
    sb8.push_back(pack(m8));
    sb0.push_back(pack(m0));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      apply(4'b0000, 1'b1, 1'b1);
      e8 = sb8.pop_front(); e0 = sb0.pop_front(); vectors += 2;
      if ({gnt_n, gnt_idx, gnt_vld, timeout} !== e8) begin
        miscompares++; $display("FAIL reset8 c%0d: got %h want %h", c, {gnt_n, gnt_idx, gnt_vld, timeout}, e8);
      end
      if ({gnt_n0, gnt_idx0, gnt_vld0, timeout0} !== e0) begin
        miscompares++; $display("FAIL reset0 c%0d: got %h want %h", c, {gnt_n0, gnt_idx0, gnt_vld0, timeout0}, e0);
      end
    end
    vectors++;
    if ({gnt_n, gnt_idx, gnt_vld, timeout} !== 8'b1111_00_0_0) begin
      miscompares++; $display("FAIL reset_const: got %b want 11110000", {gnt_n, gnt_idx, gnt_vld, timeout});
    end
  endtask

  task automatic test_single();
    int vld_cycles = 0;
    int to_seen = 0;
    for (int c = 0; c < 6; c++) begin
      apply((c < 3) ? 4'b0001 : 4'b0000, 1'b1, 1'b0);
      e8 = sb8.pop_front(); e0 = sb0.pop_front(); vectors += 2;
      if ({gnt_n, gnt_idx, gnt_vld, timeout} !== e8) begin
        miscompares++; $display("FAIL single8 c%0d: got %h want %h", c, {gnt_n, gnt_idx, gnt_vld, timeout}, e8);
      end
      if ({gnt_n0, gnt_idx0, gnt_vld0, timeout0} !== e0) begin
        miscompares++; $display("FAIL single0 c%0d: got %h want %h", c, {gnt_n0, gnt_idx0, gnt_vld0, timeout0}, e0);
      end
      if (gnt_vld) begin
        vld_cycles++;
        vectors++;
        if (gnt_n !== 4'b1110 || gnt_idx !== 2'd0) begin
          miscompares++; $display("FAIL single_sel c%0d: got n=%b idx=%0d want n=1110 idx=0", c, gnt_n, gnt_idx);
        end
      end
      if (timeout) to_seen++;
    end
    vectors++;
    if (vld_cycles != 3 || to_seen != 0) begin
      miscompares++; $display("FAIL single_len: got %0d cycles %0d timeouts want 3 and 0", vld_cycles, to_seen);
    end
  endtask

  task automatic test_rotation();
    int starts[$];
    int tos = 0;
    int vc = 0;
    logic prev = 1'b0;
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    apply(4'b0000, 1'b1, 1'b1);
    void'(sb8.pop_front()); void'(sb0.pop_front());
    for (int c = 0; c < 45; c++) begin
      apply(4'b1111, 1'b1, 1'b0);
      e8 = sb8.pop_front(); e0 = sb0.pop_front(); vectors += 2;
      if ({gnt_n, gnt_idx, gnt_vld, timeout} !== e8) begin
        miscompares++; $display("FAIL rot8 c%0d: got %h want %h", c, {gnt_n, gnt_idx, gnt_vld, timeout}, e8);
      end
      if ({gnt_n0, gnt_idx0, gnt_vld0, timeout0} !== e0) begin
        miscompares++; $display("FAIL rot0 c%0d: got %h want %h", c, {gnt_n0, gnt_idx0, gnt_vld0, timeout0}, e0);
      end
      if (gnt_vld && !prev) starts.push_back(int'(gnt_idx));
      if (gnt_vld) vc++;
      if (timeout) tos++;
      prev = gnt_vld;
    end
    vectors++;
    if (starts.size() != 5 || tos != 5 || vc != 40) begin
      miscompares++; $display("FAIL rot_count: got %0d grants %0d timeouts %0d busy want 5 5 40", starts.size(), tos, vc);
    end
    for (int i = 0; i < 5 && i < starts.size(); i++) begin
      vectors++;
      if (starts[i] != int'(exp_seq[i])) begin
        miscompares++; $display("FAIL rot_order %0d: got %0d want %0d", i, starts[i], exp_seq[i]);
      end
    end
    for (int c = 0; c < 2; c++) begin
      apply(4'b0000, 1'b1, 1'b0);
      void'(sb8.pop_front()); void'(sb0.pop_front());
    end
  endtask

  task automatic test_wrap();
    logic [3:0] pat [4];
    pat = '{4'b0010, 4'b0000, 4'b0011, 4'b0000};
    for (int c = 0; c < 4; c++) begin
      apply(pat[c], 1'b1, 1'b0);
      e8 = sb8.pop_front(); e0 = sb0.pop_front(); vectors += 2;
      if ({gnt_n, gnt_idx, gnt_vld, timeout} !== e8) begin
        miscompares++; $display("FAIL wrap8 c%0d: got %h want %h", c, {gnt_n, gnt_idx, gnt_vld, timeout}, e8);
      end
      if ({gnt_n0, gnt_idx0, gnt_vld0, timeout0} !== e0) begin
        miscompares++; $display("FAIL wrap0 c%0d: got %h want %h", c, {gnt_n0, gnt_idx0, gnt_vld0, timeout0}, e0);
      end
      if (c == 2) begin
        vectors++;
        if (gnt_n !== 4'b1110 || gnt_idx !== 2'd0 || gnt_vld !== 1'b1) begin
          miscompares++; $display("FAIL wrap_win: got n=%b idx=%0d want n=1110 idx=0", gnt_n, gnt_idx);
        end
      end
    end
  endtask

  task automatic test_unlimited();
    for (int c = 0; c < 302; c++) begin
      apply((c < 300) ? 4'b0100 : 4'b0000, 1'b1, 1'b0);
      e8 = sb8.pop_front(); e0 = sb0.pop_front(); vectors += 2;
      if ({gnt_n, gnt_idx, gnt_vld, timeout} !== e8) begin
        miscompares++; $display("FAIL unl8 c%0d: got %h want %h", c, {gnt_n, gnt_idx, gnt_vld, timeout}, e8);
      end
      if ({gnt_n0, gnt_idx0, gnt_vld0, timeout0} !== e0) begin
        miscompares++; $display("FAIL unl0 c%0d: got %h want %h", c, {gnt_n0, gnt_idx0, gnt_vld0, timeout0}, e0);
      end
      if (c < 300) begin
        vectors++;
        if (gnt_n0 !== 4'b1011 || timeout0 !== 1'b0) begin
          miscompares++; $display("FAIL unl_hold c%0d: got n=%b to=%b want 1011 0", c, gnt_n0, timeout0);
        end
      end
    end
  endtask

  task automatic test_enable();
    logic [3:0] rp [11];
    logic       ep [11];
    logic [3:0] np [11];
    rp = '{4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h8, 4'h8, 4'h0};
    ep = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    np = '{4'hf, 4'hf, 4'hf, 4'h7, 4'h7, 4'h7, 4'h7, 4'hf, 4'hf, 4'hf, 4'hf};
    for (int c = 0; c < 11; c++) begin
      apply(rp[c], ep[c], 1'b0);
      e8 = sb8.pop_front(); e0 = sb0.pop_front(); vectors += 3;
      if ({gnt_n, gnt_idx, gnt_vld, timeout} !== e8) begin
        miscompares++; $display("FAIL en8 c%0d: got %h want %h", c, {gnt_n, gnt_idx, gnt_vld, timeout}, e8);
      end
      if ({gnt_n0, gnt_idx0, gnt_vld0, timeout0} !== e0) begin
        miscompares++; $display("FAIL en0 c%0d: got %h want %h", c, {gnt_n0, gnt_idx0, gnt_vld0, timeout0}, e0);
      end
      if (gnt_n !== np[c]) begin
        miscompares++; $display("FAIL en_sel c%0d: got %b want %b", c, gnt_n, np[c]);
      end
    end
  endtask

  task automatic test_same_edge();
    for (int c = 0; c < 10; c++) begin
      apply((c < 8) ? 4'b0001 : 4'b0000, 1'b1, 1'b0);
      e8 = sb8.pop_front(); e0 = sb0.pop_front(); vectors += 2;
      if ({gnt_n, gnt_idx, gnt_vld, timeout} !== e8) begin
        miscompares++; $display("FAIL edge8 c%0d: got %h want %h", c, {gnt_n, gnt_idx, gnt_vld, timeout}, e8);
      end
      if ({gnt_n0, gnt_idx0, gnt_vld0, timeout0} !== e0) begin
        miscompares++; $display("FAIL edge0 c%0d: got %h want %h", c, {gnt_n0, gnt_idx0, gnt_vld0, timeout0}, e0);
      end
      if (c == 8) begin
        vectors++;
        if (timeout !== 1'b0 || gnt_vld !== 1'b0) begin
          miscompares++; $display("FAIL edge_prio: got to=%b vld=%b want 0 0", timeout, gnt_vld);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] rp [5];
    logic       sp [5];
    rp = '{4'b0010, 4'b1111, 4'b1111, 4'b0000, 4'b0000};
    sp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int c = 0; c < 5; c++) begin
      apply(rp[c], 1'b1, sp[c]);
      e8 = sb8.pop_front(); e0 = sb0.pop_front(); vectors += 2;
      if ({gnt_n, gnt_idx, gnt_vld, timeout} !== e8) begin
        miscompares++; $display("FAIL rstmid8 c%0d: got %h want %h", c, {gnt_n, gnt_idx, gnt_vld, timeout}, e8);
      end
      if ({gnt_n0, gnt_idx0, gnt_vld0, timeout0} !== e0) begin
        miscompares++; $display("FAIL rstmid0 c%0d: got %h want %h", c, {gnt_n0, gnt_idx0, gnt_vld0, timeout0}, e0);
      end
      vectors++;
      case (c)
        0: if (gnt_n !== 4'b1101) begin
             miscompares++; $display("FAIL rstmid_pre: got %b want 1101", gnt_n);
           end
        1: if ({gnt_n, gnt_vld, timeout} !== 6'b1111_0_0) begin
             miscompares++; $display("FAIL rstmid_drop: got %b want 111100", {gnt_n, gnt_vld, timeout});
           end
        2: if (gnt_n !== 4'b1110 || gnt_idx !== 2'd0) begin
             miscompares++; $display("FAIL rstmid_next: got n=%b idx=%0d want 1110 0", gnt_n, gnt_idx);
           end
        default: if (gnt_n === 4'b0000) begin
             miscompares++; $display("FAIL rstmid_tail: got %b want a one-hot-low or idle select", gnt_n);
           end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_unlimited();
    test_enable();
    test_same_edge();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
